// File: rtl/fetch_pkg.sv
// Shared state encoding, widths and default step for the fetch PC sequencer.
package fetch_pkg;
   localparam int ADDR_W          = 64;
   localparam int INSTR_W         = 32;
   localparam int DEFAULT_PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT_OUT,
      SQUASH
   } fetch_state_e;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC logic: sequential successor, branch target and taken decision.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int PC_STEP = DEFAULT_PC_STEP
) (
   input  logic [ADDR_W-1:0] PC_i,
   input  logic [ADDR_W-1:0] ResolvePC_i,
   input  logic [ADDR_W-1:0] SignExtImm64_i,
   input  logic              Branch_i,
   input  logic              UCbranch_i,
   input  logic              ALUZero_i,
   input  logic              ResolveValid_i,
   output logic [ADDR_W-1:0] SeqPC_o,
   output logic [ADDR_W-1:0] Target_o,
   output logic              Taken_o
);
   assign SeqPC_o  = PC_i + ADDR_W'(PC_STEP);
   // Target wraps modulo 2^64 by construction of the 64-bit add.
   assign Target_o = ResolvePC_i + SignExtImm64_i;
   assign Taken_o  = ResolveValid_i && (UCbranch_i || (Branch_i && ALUZero_i));
endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch controller: owns the PC, issues single outstanding imem requests, feeds a one-entry
// decode slot and redirects on taken branches. Define FETCH_STATS_EN for taken/squash counters.
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic               CLK_i,
   input  logic               Reset_i,
   output logic               ImemReq_o,
   output logic [ADDR_W-1:0]  ImemAddr_o,
   input  logic               ImemAck_i,
   input  logic [INSTR_W-1:0] ImemInstr_i,
   output logic               InstrValid_o,
   output logic [INSTR_W-1:0] Instr_o,
   output logic [ADDR_W-1:0]  InstrPC_o,
   input  logic               InstrReady_i,
   input  logic               ResolveValid_i,
   input  logic               Branch_i,
   input  logic               UCbranch_i,
   input  logic               ALUZero_i,
   input  logic [ADDR_W-1:0]  ResolvePC_i,
   input  logic [ADDR_W-1:0]  SignExtImm64_i,
   output logic               Redirect_o
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        TakenCount_o,
   output logic [31:0]        SquashCount_o
`endif
);
   fetch_state_e       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  instr_pc_q;
   logic               redirect_q;

   logic [ADDR_W-1:0]  seq_pc_d;
   logic [ADDR_W-1:0]  target_d;
   logic               taken;
   logic               imem_req;
   logic               ack;
   logic               consume;

   next_pc_calc #(.PC_STEP(PC_STEP)) u_next_pc (
      .PC_i           (pc_q),
      .ResolvePC_i    (ResolvePC_i),
      .SignExtImm64_i (SignExtImm64_i),
      .Branch_i       (Branch_i),
      .UCbranch_i     (UCbranch_i),
      .ALUZero_i      (ALUZero_i),
      .ResolveValid_i (ResolveValid_i),
      .SeqPC_o        (seq_pc_d),
      .Target_o       (target_d),
      .Taken_o        (taken)
   );

   // A fetch request only shows while the slot is empty or draining this cycle, so an ack
   // can never land on an unconsumed instruction; a squash always holds its request.
   assign imem_req = (state_q == SQUASH) ||
                     ((state_q == FETCH) && (!valid_q || InstrReady_i));
   assign ack      = imem_req && ImemAck_i;
   assign consume  = valid_q && InstrReady_i;

   always_ff @(posedge CLK_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         redirect_q <= 1'b0;
      end else begin
         redirect_q <= taken;
         if (taken) begin
            pc_q    <= target_d;
            valid_q <= 1'b0;
            if (imem_req && !ImemAck_i) begin
               state_q <= SQUASH;
            end else begin
               state_q <= FETCH;
               addr_q  <= target_d;
            end
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= FETCH;
                  addr_q  <= pc_q;
               end
               FETCH: begin
                  if (ack) begin
                     instr_q    <= ImemInstr_i;
                     instr_pc_q <= pc_q;
                     valid_q    <= 1'b1;
                     pc_q       <= seq_pc_d;
                     addr_q     <= seq_pc_d;
                  end else if (consume) begin
                     valid_q <= 1'b0;
                  end else if (valid_q) begin
                     state_q <= WAIT_OUT;
                  end
               end
               WAIT_OUT: begin
                  if (consume) begin
                     valid_q <= 1'b0;
                     state_q <= FETCH;
                  end
               end
               SQUASH: begin
                  if (ImemAck_i) begin
                     state_q <= FETCH;
                     addr_q  <= pc_q;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ImemReq_o    = imem_req;
   assign ImemAddr_o   = addr_q;
   assign InstrValid_o = valid_q;
   assign Instr_o      = instr_q;
   assign InstrPC_o    = instr_pc_q;
   assign Redirect_o   = redirect_q;

`ifdef FETCH_STATS_EN
   logic [31:0] taken_cnt_q;
   logic [31:0] squash_cnt_q;

   always_ff @(posedge CLK_i or posedge Reset_i) begin
      if (Reset_i) begin
         taken_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (taken) taken_cnt_q <= taken_cnt_q + 32'd1;
         if (ack && (taken || (state_q == SQUASH))) squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign TakenCount_o  = taken_cnt_q;
   assign SquashCount_o = squash_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios plus a randomized run
// against a flag-based behavioural model.
module tb_fetch_pc_sequencer;
   import fetch_pkg::*;

   logic               CLK = 1'b0;
   logic               Reset = 1'b1;
   logic               ImemReq;
   logic [ADDR_W-1:0]  ImemAddr;
   logic               ImemAck;
   logic [INSTR_W-1:0] ImemInstr;
   logic               InstrValid;
   logic [INSTR_W-1:0] Instr;
   logic [ADDR_W-1:0]  InstrPC;
   logic               InstrReady;
   logic               ResolveValid;
   logic               Branch;
   logic               UCbranch;
   logic               ALUZero;
   logic [ADDR_W-1:0]  ResolvePC;
   logic [ADDR_W-1:0]  SignExtImm64;
   logic               Redirect;
`ifdef FETCH_STATS_EN
   logic [31:0]        TakenCount;
   logic [31:0]        SquashCount;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   fetch_pc_sequencer #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
      .CLK_i          (CLK),
      .Reset_i        (Reset),
      .ImemReq_o      (ImemReq),
      .ImemAddr_o     (ImemAddr),
      .ImemAck_i      (ImemAck),
      .ImemInstr_i    (ImemInstr),
      .InstrValid_o   (InstrValid),
      .Instr_o        (Instr),
      .InstrPC_o      (InstrPC),
      .InstrReady_i   (InstrReady),
      .ResolveValid_i (ResolveValid),
      .Branch_i       (Branch),
      .UCbranch_i     (UCbranch),
      .ALUZero_i      (ALUZero),
      .ResolvePC_i    (ResolvePC),
      .SignExtImm64_i (SignExtImm64),
      .Redirect_o     (Redirect)
`ifdef FETCH_STATS_EN
      ,
      .TakenCount_o   (TakenCount),
      .SquashCount_o  (SquashCount)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ImemAck      = 1'b0;
      ImemInstr    = '0;
      InstrReady   = 1'b0;
      ResolveValid = 1'b0;
      Branch       = 1'b0;
      UCbranch     = 1'b0;
      ALUZero      = 1'b0;
      ResolvePC    = '0;
      SignExtImm64 = '0;
   endtask

   // Leaves the DUT one edge past reset release, i.e. in its first fetch cycle at RESET_PC.
   task automatic do_reset();
      clear_inputs();
      Reset = 1'b1;
      cyc();
      cyc();
      Reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      clear_inputs();
      Reset = 1'b1;
      cyc();
      cyc();
      ImemAck = 1'b1;
      InstrReady = 1'b1;
      #1;
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL reset_req got %b want 0", ImemReq); n_fail++; end
      n_tests++; if (ImemAddr !== 64'h0) begin $display("FAIL reset_addr got %h want 0", ImemAddr); n_fail++; end
      n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", InstrValid); n_fail++; end
      n_tests++; if (Instr !== 32'h0) begin $display("FAIL reset_instr got %h want 0", Instr); n_fail++; end
      n_tests++; if (InstrPC !== 64'h0) begin $display("FAIL reset_instrpc got %h want 0", InstrPC); n_fail++; end
      n_tests++; if (Redirect !== 1'b0) begin $display("FAIL reset_redirect got %b want 0", Redirect); n_fail++; end
      clear_inputs();
      Reset = 1'b0;
      #1;
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL idle_req got %b want 0", ImemReq); n_fail++; end
      cyc();
      n_tests++; if (ImemReq !== 1'b1) begin $display("FAIL first_req got %b want 1", ImemReq); n_fail++; end
      n_tests++; if (ImemAddr !== 64'h0) begin $display("FAIL first_addr got %h want 0", ImemAddr); n_fail++; end
`ifdef FETCH_STATS_EN
      n_tests++; if (TakenCount !== 32'd0 || SquashCount !== 32'd0) begin
         $display("FAIL reset_stats got %0d/%0d want 0/0", TakenCount, SquashCount); n_fail++; end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      InstrReady = 1'b1;
      ImemAck = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ImemInstr = 32'hA000_0000 + 32'(k);
         #1;
         n_tests++; if (ImemReq !== 1'b1) begin $display("FAIL b2b_req[%0d] got %b want 1", k, ImemReq); n_fail++; end
         n_tests++; if (ImemAddr !== 64'(4 * k)) begin $display("FAIL b2b_addr[%0d] got %h want %h", k, ImemAddr, 64'(4 * k)); n_fail++; end
         if (k > 0) begin
            n_tests++; if (InstrValid !== 1'b1) begin $display("FAIL b2b_valid[%0d] got %b want 1", k, InstrValid); n_fail++; end
            n_tests++; if (InstrPC !== 64'(4 * (k - 1))) begin $display("FAIL b2b_pc[%0d] got %h want %h", k, InstrPC, 64'(4 * (k - 1))); n_fail++; end
            n_tests++; if (Instr !== 32'hA000_0000 + 32'(k - 1)) begin $display("FAIL b2b_instr[%0d] got %h want %h", k, Instr, 32'hA000_0000 + 32'(k - 1)); n_fail++; end
         end
         cyc();
      end
   endtask

   task automatic test_wait_out();
      do_reset();
      ImemAck = 1'b1;
      ImemInstr = 32'h1111_0001;
      #1;
      n_tests++; if (ImemReq !== 1'b1) begin $display("FAIL wo_req0 got %b want 1", ImemReq); n_fail++; end
      cyc();
      ImemAck = 1'b0;
      #1;
      n_tests++; if (InstrValid !== 1'b1) begin $display("FAIL wo_valid got %b want 1", InstrValid); n_fail++; end
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL wo_req_blocked got %b want 0", ImemReq); n_fail++; end
      cyc();
      cyc();
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL wo_req_hold got %b want 0", ImemReq); n_fail++; end
      n_tests++; if (Instr !== 32'h1111_0001) begin $display("FAIL wo_instr_stable got %h want 11110001", Instr); n_fail++; end
      n_tests++; if (InstrPC !== 64'h0) begin $display("FAIL wo_pc_stable got %h want 0", InstrPC); n_fail++; end
      InstrReady = 1'b1;
      #1;
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL wo_req_drain got %b want 0", ImemReq); n_fail++; end
      cyc();
      InstrReady = 1'b0;
      #1;
      n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL wo_consumed got %b want 0", InstrValid); n_fail++; end
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h4) begin
         $display("FAIL wo_resume got req=%b addr=%h want req=1 addr=4", ImemReq, ImemAddr); n_fail++; end
   endtask

   task automatic test_redirect_uc();
      do_reset();
      ImemAck = 1'b1;
      ImemInstr = 32'h2222_0000;
      cyc();
      ImemAck = 1'b0;
      ResolveValid = 1'b1;
      UCbranch = 1'b1;
      ResolvePC = 64'h10;
      SignExtImm64 = 64'h10;
      #1;
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL uc_no_outstanding got %b want 0", ImemReq); n_fail++; end
      cyc();
      clear_inputs();
      #1;
      n_tests++; if (Redirect !== 1'b1) begin $display("FAIL uc_redirect got %b want 1", Redirect); n_fail++; end
      n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL uc_flush got %b want 0", InstrValid); n_fail++; end
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h20) begin
         $display("FAIL uc_target got req=%b addr=%h want req=1 addr=20", ImemReq, ImemAddr); n_fail++; end
`ifdef FETCH_STATS_EN
      n_tests++; if (TakenCount !== 32'd1 || SquashCount !== 32'd0) begin
         $display("FAIL uc_stats got %0d/%0d want 1/0", TakenCount, SquashCount); n_fail++; end
`endif
      cyc();
      n_tests++; if (Redirect !== 1'b0) begin $display("FAIL uc_pulse_width got %b want 0", Redirect); n_fail++; end
   endtask

   task automatic test_cond_branch();
      do_reset();
      InstrReady = 1'b1;
      ResolveValid = 1'b1;
      Branch = 1'b1;
      ALUZero = 1'b0;
      ResolvePC = 64'h10;
      SignExtImm64 = 64'h10;
      cyc();
      ResolveValid = 1'b0;
      Branch = 1'b0;
      #1;
      n_tests++; if (Redirect !== 1'b0) begin $display("FAIL nt_redirect got %b want 0", Redirect); n_fail++; end
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h0) begin
         $display("FAIL nt_addr got req=%b addr=%h want req=1 addr=0", ImemReq, ImemAddr); n_fail++; end
      ImemAck = 1'b1;
      ImemInstr = 32'h3333_0000;
      cyc();
      ImemAck = 1'b0;
      #1;
      n_tests++; if (ImemAddr !== 64'h4 || InstrValid !== 1'b1 || InstrPC !== 64'h0) begin
         $display("FAIL nt_seq got addr=%h valid=%b pc=%h want 4/1/0", ImemAddr, InstrValid, InstrPC); n_fail++; end
      ResolveValid = 1'b1;
      Branch = 1'b1;
      ALUZero = 1'b1;
      ImemAck = 1'b1;
      ImemInstr = 32'h4444_0000;
      cyc();
      clear_inputs();
      InstrReady = 1'b1;
      #1;
      n_tests++; if (Redirect !== 1'b1) begin $display("FAIL tk_redirect got %b want 1", Redirect); n_fail++; end
      n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL tk_ack_discarded got %b want 0", InstrValid); n_fail++; end
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h20) begin
         $display("FAIL tk_target got req=%b addr=%h want req=1 addr=20", ImemReq, ImemAddr); n_fail++; end
`ifdef FETCH_STATS_EN
      n_tests++; if (TakenCount !== 32'd1 || SquashCount !== 32'd1) begin
         $display("FAIL tk_stats got %0d/%0d want 1/1", TakenCount, SquashCount); n_fail++; end
`endif
   endtask

   task automatic test_squash();
      do_reset();
      InstrReady = 1'b1;
      ImemAck = 1'b1;
      cyc();
      cyc();
      ImemAck = 1'b0;
      ResolveValid = 1'b1;
      UCbranch = 1'b1;
      ResolvePC = 64'h100;
      SignExtImm64 = 64'h40;
      #1;
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h8) begin
         $display("FAIL sq_pre got req=%b addr=%h want req=1 addr=8", ImemReq, ImemAddr); n_fail++; end
      cyc();
      ResolveValid = 1'b0;
      UCbranch = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h8) begin
            $display("FAIL sq_hold[%0d] got req=%b addr=%h want req=1 addr=8", i, ImemReq, ImemAddr); n_fail++; end
         n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL sq_valid[%0d] got %b want 0", i, InstrValid); n_fail++; end
         n_tests++; if (Redirect !== (i == 0)) begin $display("FAIL sq_redirect[%0d] got %b want %b", i, Redirect, i == 0); n_fail++; end
         cyc();
      end
      ImemAck = 1'b1;
      ImemInstr = 32'hDEAD_BEEF;
      #1;
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h8) begin
         $display("FAIL sq_ack_addr got req=%b addr=%h want req=1 addr=8", ImemReq, ImemAddr); n_fail++; end
      cyc();
      ImemAck = 1'b0;
      #1;
      n_tests++; if (InstrValid !== 1'b0) begin $display("FAIL sq_discard got %b want 0", InstrValid); n_fail++; end
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h140) begin
         $display("FAIL sq_target got req=%b addr=%h want req=1 addr=140", ImemReq, ImemAddr); n_fail++; end
`ifdef FETCH_STATS_EN
      n_tests++; if (TakenCount !== 32'd1 || SquashCount !== 32'd1) begin
         $display("FAIL sq_stats got %0d/%0d want 1/1", TakenCount, SquashCount); n_fail++; end
`endif
      ImemAck = 1'b1;
      ImemInstr = 32'h5555_0140;
      cyc();
      ImemAck = 1'b0;
      #1;
      n_tests++; if (InstrValid !== 1'b1 || InstrPC !== 64'h140 || Instr !== 32'h5555_0140) begin
         $display("FAIL sq_first_target got valid=%b pc=%h instr=%h want 1/140/55550140", InstrValid, InstrPC, Instr); n_fail++; end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      InstrReady = 1'b1;
      ImemAck = 1'b1;
      cyc();
      ImemAck = 1'b0;
      #1;
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h4 || InstrValid !== 1'b1) begin
         $display("FAIL rm_pre got req=%b addr=%h valid=%b want 1/4/1", ImemReq, ImemAddr, InstrValid); n_fail++; end
      Reset = 1'b1;
      #1;
      n_tests++; if (ImemReq !== 1'b0 || InstrValid !== 1'b0 || ImemAddr !== 64'h0) begin
         $display("FAIL rm_async got req=%b valid=%b addr=%h want 0/0/0", ImemReq, InstrValid, ImemAddr); n_fail++; end
      cyc();
      Reset = 1'b0;
      #1;
      n_tests++; if (ImemReq !== 1'b0) begin $display("FAIL rm_idle got %b want 0", ImemReq); n_fail++; end
      cyc();
      n_tests++; if (ImemReq !== 1'b1 || ImemAddr !== 64'h0) begin
         $display("FAIL rm_restart got req=%b addr=%h want req=1 addr=0", ImemReq, ImemAddr); n_fail++; end
   endtask

   // Model tracks only "squashing", "stalled on a full slot" and slot contents; requests
   // follow from those flags and the current InstrReady.
   task automatic test_random();
      logic [ADDR_W-1:0]  m_pc = 64'h0;
      logic [ADDR_W-1:0]  m_sq_addr = 64'h0;
      logic               m_squash = 1'b0;
      logic               m_stall = 1'b0;
      logic               m_valid = 1'b0;
      logic [INSTR_W-1:0] m_instr = '0;
      logic [ADDR_W-1:0]  m_ipc = '0;
      logic               m_redirect = 1'b0;
      logic [31:0]        m_tk_cnt = 32'd0;
      logic [31:0]        m_sq_cnt = 32'd0;
      logic               exp_req;
      logic [ADDR_W-1:0]  exp_addr;
      logic               tk;
      logic [ADDR_W-1:0]  tgt;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         ImemAck      = ($urandom_range(0, 99) < 55);
         InstrReady   = ($urandom_range(0, 99) < 65);
         ImemInstr    = $urandom;
         ResolveValid = ($urandom_range(0, 99) < 12);
         Branch       = $urandom_range(0, 1) == 1;
         UCbranch     = $urandom_range(0, 3) == 0;
         ALUZero      = $urandom_range(0, 1) == 1;
         ResolvePC    = {$urandom, $urandom} & ~64'h3;
         SignExtImm64 = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255)) * 64'd4;
         #1;
         exp_req  = m_squash || (!m_stall && (!m_valid || InstrReady));
         exp_addr = m_squash ? m_sq_addr : m_pc;
         n_tests++; if (ImemReq !== exp_req) begin $display("FAIL rnd_req@%0d got %b want %b", c, ImemReq, exp_req); n_fail++; end
         if (exp_req) begin
            n_tests++; if (ImemAddr !== exp_addr) begin $display("FAIL rnd_addr@%0d got %h want %h", c, ImemAddr, exp_addr); n_fail++; end
         end
         n_tests++; if (InstrValid !== m_valid) begin $display("FAIL rnd_valid@%0d got %b want %b", c, InstrValid, m_valid); n_fail++; end
         if (m_valid) begin
            n_tests++; if (Instr !== m_instr || InstrPC !== m_ipc) begin
               $display("FAIL rnd_slot@%0d got %h/%h want %h/%h", c, Instr, InstrPC, m_instr, m_ipc); n_fail++; end
         end
         n_tests++; if (Redirect !== m_redirect) begin $display("FAIL rnd_redirect@%0d got %b want %b", c, Redirect, m_redirect); n_fail++; end
`ifdef FETCH_STATS_EN
         n_tests++; if (TakenCount !== m_tk_cnt || SquashCount !== m_sq_cnt) begin
            $display("FAIL rnd_stats@%0d got %0d/%0d want %0d/%0d", c, TakenCount, SquashCount, m_tk_cnt, m_sq_cnt); n_fail++; end
`endif
         tk  = ResolveValid && (UCbranch || (Branch && ALUZero));
         tgt = ResolvePC + SignExtImm64;
         if (tk) begin
            if (exp_req && ImemAck) m_sq_cnt++;
            if (exp_req && !ImemAck) begin
               if (!m_squash) m_sq_addr = m_pc;
               m_squash = 1'b1;
            end else begin
               m_squash = 1'b0;
            end
            m_pc = tgt;
            m_valid = 1'b0;
            m_stall = 1'b0;
            m_tk_cnt++;
         end else if (m_squash) begin
            if (ImemAck) begin
               m_squash = 1'b0;
               m_sq_cnt++;
            end
         end else if (m_stall) begin
            if (m_valid && InstrReady) begin
               m_valid = 1'b0;
               m_stall = 1'b0;
            end
         end else if (exp_req && ImemAck) begin
            m_instr = ImemInstr;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
         end else if (m_valid && InstrReady) begin
            m_valid = 1'b0;
         end else if (m_valid) begin
            m_stall = 1'b1;
         end
         m_redirect = tk;
         cyc();
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_back_to_back();
      test_wait_out();
      test_redirect_uc();
      test_cond_branch();
      test_squash();
      test_reset_mid_fetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Sequential fetch controller that owns the architectural PC, issues one-at-a-time instruction-memory requests, and hands fetched instructions to decode through a one-entry output register with valid/ready.
Takes branch-resolution results from execute and redirects the PC, squashing wrong-path fetches.
Sits between instruction memory and decode and replaces the free-running PC register of the single-cycle core.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
ImemReq  out  1  fetch request to instruction memory
ImemAddr  out  64  fetch byte address
ImemAck  in  1  memory returns ImemInstr this cycle
ImemInstr  in  32  fetched instruction word
InstrValid  out  1  output register holds an instruction
Instr  out  32  instruction to decode
InstrPC  out  64  PC of Instr
InstrReady  in  1  decode accepts Instr this cycle
ResolveValid  in  1  execute presents a branch resolution
Branch  in  1  conditional branch (CBZ-type)
UCbranch  in  1  unconditional branch
ALUZero  in  1  ALU zero flag for the conditional branch
ResolvePC  in  64  PC of the resolving branch
SignExtImm64  in  64  branch byte offset, already scaled
Redirect  out  1  one-cycle pulse: PC redirected, pipeline flushed

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=IDLE, ImemReq=0, ImemAddr=0, InstrValid=0, Instr=0, InstrPC=0, Redirect=0.
- States: IDLE, FETCH, WAIT_OUT, SQUASH.
- IDLE: entered only from reset. Moves to FETCH on the first clock after Reset deasserts. No request in IDLE.
- FETCH: ImemReq=1, ImemAddr=PC, held stable until ImemAck. Ack in cycle N gives: Instr=ImemInstr, InstrPC=PC, InstrValid=1 in cycle N+1, and PC<=PC+PC_STEP.
  - After an ack, stay in FETCH (back-to-back) if the output slot frees in N+1, meaning InstrReady is sampled high in N+1. Otherwise go to WAIT_OUT.
- WAIT_OUT: ImemReq=0. When InstrValid&&InstrReady, the slot is consumed and the state returns to FETCH the same edge.
- Slot-free rule: a new request is only started when the slot is empty or draining that cycle. This guarantees an ack can never collide with an unconsumed instruction.
- Consume: InstrValid&&InstrReady clears InstrValid unless an ack loads the slot on the same edge.
- Taken: ResolveValid && (UCbranch || (Branch && ALUZero)). Target = ResolvePC + SignExtImm64, 64-bit modulo (wraps, no flag). Not-taken and ResolveValid=0 have no effect.
- On a taken resolution:
  - PC<=target. InstrValid<=0 (flush). Redirect=1 for exactly the next cycle.
  - If a request is outstanding without ack this cycle: go to SQUASH.
  - Otherwise go to FETCH at target. An ack arriving in the same cycle is discarded.
- Priority: Reset > taken redirect > ack > consume.
- SQUASH: hold ImemReq=1 and the old ImemAddr until ImemAck, discard the data, then go to FETCH at the target. A second taken resolution in SQUASH only updates PC. Redirect pulses again.
- UCbranch and Branch both high: treated as taken.

Optional Feature:
FETCH_STATS_EN: adds output ports TakenCount[31:0] and SquashCount[31:0].
- TakenCount increments once per taken redirect.
- SquashCount increments once per discarded ImemAck.
- Both reset to 0 and wrap at 2^32.
Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
Package fetch_pkg:
- state enum {IDLE, FETCH, WAIT_OUT, SQUASH}
- ADDR_W=64, INSTR_W=32
- default PC_STEP constant
Sub-module next_pc_calc, combinational: inputs PC, ResolvePC, SignExtImm64, Branch, UCbranch, ALUZero, ResolveValid. Outputs SeqPC, Target, Taken.

Test Plan:
- Reset with RESET_PC=0, ack every cycle, InstrReady=1 -> addresses 0x0,0x4,0x8 on consecutive cycles; InstrValid one cycle after each ack with InstrPC=0x0,0x4,0x8.
- InstrReady=0 after the first instruction -> WAIT_OUT, ImemReq=0, Instr/InstrPC stable. Raise InstrReady -> next request at 0x4.
- ResolvePC=0x10, Imm=0x10, UCbranch=1, no outstanding request -> Redirect pulse, next ImemAddr=0x20, InstrValid flushed.
- Branch=1, ALUZero=0 with ResolvePC=0x10, Imm=0x10 -> no redirect, sequential addresses continue. Same with ALUZero=1 -> ImemAddr=0x20.
- Taken redirect while the request to 0x8 is unacked, ack 3 cycles later -> ImemAddr held at 0x8, data discarded (InstrValid stays 0), then fetch at target; with FETCH_STATS_EN, SquashCount=1 and TakenCount=1.
- Assert Reset mid-FETCH with the request outstanding -> ImemReq and InstrValid drop immediately; after release, the first request is at RESET_PC.
